// File: rtl/mm2s_pkg.sv
// rtl/mm2s_pkg.sv - shared state type and width helpers for the mm2s egress path
package mm2s_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic int id_width(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  // Wide enough to hold max_beats itself; unlimited mode still needs one bit.
  function automatic int beat_cnt_width(input int max_beats);
    return (max_beats > 0) ? $clog2(max_beats + 1) : 1;
  endfunction

endpackage

// File: rtl/mm2s_rr_pick.sv
// rtl/mm2s_rr_pick.sv - round-robin winner select: rotate, priority-encode, rotate back
module mm2s_rr_pick
  import mm2s_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_last_id,
  output logic [ID_WIDTH-1:0] o_winner,
  output logic                o_any_req
);

  logic [2*NUM_SRC-1:0] w_req_dbl;
  logic [NUM_SRC-1:0]   w_req_rot;
  int                   w_start;
  int                   w_offset;
  int                   w_sum;

  // Doubling the request vector turns the rotation into a plain part-select.
  always_comb begin
    w_start = int'(i_last_id) + 1;
    if (w_start >= NUM_SRC) w_start = 0;
    w_req_dbl = {i_req, i_req};
    w_req_rot = w_req_dbl[w_start +: NUM_SRC];
    w_offset  = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_offset = i;
    end
    w_sum = w_start + w_offset;
    if (w_sum >= NUM_SRC) w_sum = w_sum - NUM_SRC;
    o_winner = ID_WIDTH'(w_sum);
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/mm2s_egress_arbiter.sv
// rtl/mm2s_egress_arbiter.sv - per-packet round-robin arbiter onto the egress FIFO write port
module mm2s_egress_arbiter
  import mm2s_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_BEATS  = 16,
  parameter int ID_WIDTH   = id_width(NUM_SRC)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_SRC-1:0]            src_enable,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          busy
);

  localparam int                  CNT_W       = beat_cnt_width(MAX_BEATS);
  localparam logic [CNT_W-1:0]    LAST_CNT    = CNT_W'(MAX_BEATS > 0 ? MAX_BEATS - 1 : 0);
  localparam logic [ID_WIDTH-1:0] LAST_ID_RST = ID_WIDTH'(NUM_SRC - 1);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [ID_WIDTH-1:0]   r_last_id;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [ID_WIDTH-1:0]   w_winner;
  logic [NUM_SRC-1:0]    w_req;
  logic                  w_any_req;
  logic                  w_src_valid;
  logic                  w_src_last;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  w_beat;
  logic                  w_cnt_limit;
  logic                  w_release;

  assign w_req = s_axis_tvalid & src_enable;

  mm2s_rr_pick #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .i_req     (w_req),
    .i_last_id (r_last_id),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_src_valid = 1'b0;
    w_src_last  = 1'b0;
    w_src_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant_id == ID_WIDTH'(i)) begin
        w_src_valid = s_axis_tvalid[i];
        w_src_last  = s_axis_tlast[i];
        w_src_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Derived from the source side so release does not loop through the output block.
  assign w_beat      = (r_state == ST_GRANT) & w_src_valid & m_axis_tready;
  assign w_cnt_limit = (MAX_BEATS > 0) && (r_beat_cnt == LAST_CNT);
  assign w_release   = w_beat & (w_src_last | w_cnt_limit);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    s_axis_tready = '0;
    busy          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next_state = ST_GRANT;
      end
      ST_GRANT: begin
        busy          = 1'b1;
        m_axis_tvalid = w_src_valid;
        m_axis_tdata  = w_src_data;
        m_axis_tlast  = w_src_last;
        m_axis_tid    = r_grant_id;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (r_grant_id == ID_WIDTH'(i)) s_axis_tready[i] = m_axis_tready;
        end
        if (w_release) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant_id <= '0;
      r_last_id  <= LAST_ID_RST;
      r_beat_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_beat_cnt <= '0;
      if (w_any_req) r_grant_id <= w_winner;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      if (w_release) r_last_id <= r_grant_id;
    end
  end

endmodule

// File: tb/tb_mm2s_egress_arbiter.sv
// tb/tb_mm2s_egress_arbiter.sv - vector table, directed corner sequences and randomized reference-model check
module tb_mm2s_egress_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXB = 16;
  localparam int IDW  = 2;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    src_enable;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tlast;
  logic [IDW-1:0]  m_axis_tid;
  logic            busy;

  always #5 aclk = ~aclk;

  mm2s_egress_arbiter #(
    .NUM_SRC    (N),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .src_enable    (src_enable),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] en;
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         mr;
    logic         e_busy;
    logic         e_mvalid;
    logic         e_tlast;
    logic [IDW-1:0] e_tid;
    logic [N-1:0] e_tready;
  } vec_t;
  vec_t tbl[19];

  typedef struct {
    int            tid;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;
  beat_t obs_q[$];

  // Source generators: seq counts beats delivered, ppos/plen frame packets.
  int            seq[N];
  int            ppos[N];
  int            plen[N];
  int            remaining[N];
  bit            rnd_mode;
  logic [N-1:0]  cur_valid;
  logic [N-1:0]  cur_last;
  logic [DW-1:0] cur_data[N];

  // Reference model: who owns the port, who owned it last, beats in this grant.
  bit mo_on;
  int mo_g;
  int mo_last;
  int mo_beats;

  task automatic model_reset();
    mo_on = 0; mo_g = 0; mo_last = N - 1; mo_beats = 0;
    rnd_mode = 0;
    obs_q.delete();
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; ppos[i] = 0; plen[i] = 1; remaining[i] = 0;
    end
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    src_enable    = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tid", m_axis_tid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    aresetn = 1'b1;
    model_reset();
  endtask

  task automatic drive_inputs(input logic [N-1:0] en, input logic mr);
    logic [N*DW-1:0] flat;
    for (int i = 0; i < N; i++) begin
      cur_valid[i] = (remaining[i] != 0) && (!rnd_mode || ($urandom_range(3) != 0));
      cur_last[i]  = (ppos[i] == plen[i] - 1);
      cur_data[i]  = {4'(i), 28'(seq[i])};
      flat[i*DW +: DW] = cur_data[i];
    end
    src_enable    = en;
    s_axis_tvalid = cur_valid;
    s_axis_tlast  = cur_last;
    s_axis_tdata  = flat;
    m_axis_tready = mr;
  endtask

  task automatic cycle(input logic [N-1:0] en, input logic mr);
    bit ev;
    bit hs;
    int g;
    @(negedge aclk);
    drive_inputs(en, mr);
    #1;
    g  = mo_g;
    ev = mo_on && cur_valid[g];
    chk("busy", busy, mo_on);
    chk("m_tvalid", m_axis_tvalid, ev);
    chk("m_tid", m_axis_tid, mo_on ? g : 0);
    chk("m_tlast", m_axis_tlast, mo_on ? cur_last[g] : 1'b0);
    chk("m_tdata", m_axis_tdata, mo_on ? cur_data[g] : '0);
    chk("s_tready", s_axis_tready, (mo_on && mr) ? (1 << g) : 0);
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1)
      obs_q.push_back('{int'(m_axis_tid), m_axis_tdata, m_axis_tlast});
    hs = ev && mr;
    if (!mo_on) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (mo_last + k) % N;
        if (cur_valid[c] && en[c]) begin
          mo_g = c; mo_on = 1; mo_beats = 0;
          break;
        end
      end
    end else if (hs) begin
      mo_beats++;
      seq[g]++;
      if (cur_last[g]) begin
        ppos[g] = 0;
        if (rnd_mode) plen[g] = $urandom_range(40, 1);
      end else begin
        ppos[g]++;
      end
      if (remaining[g] > 0) remaining[g]--;
      if (cur_last[g] || mo_beats == MAXB) begin
        mo_on = 0; mo_last = g;
      end
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = !mo_on;
    for (int i = 0; i < N; i++) if (remaining[i] != 0) r = 0;
    return r;
  endfunction

  task automatic run_until_done(input int budget, input bit toggle);
    int c;
    c = 0;
    while (c < budget && !all_idle()) begin
      cycle(4'hF, (toggle && (c % 2 != 0)) ? 1'b0 : 1'b1);
      c++;
    end
    chk("done_in_budget", c < budget, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Two 3-beat packets from src0/src2 with one stall, then enable mask 1011.
    tbl[0]  = '{1'b1, 4'hF, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[1]  = '{1'b0, 4'hF, 4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1};
    tbl[2]  = '{1'b0, 4'hF, 4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1};
    tbl[3]  = '{1'b0, 4'hF, 4'h5, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1};
    tbl[4]  = '{1'b0, 4'hF, 4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[5]  = '{1'b0, 4'hF, 4'h4, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'h4};
    tbl[6]  = '{1'b0, 4'hF, 4'h4, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 4'h0};
    tbl[7]  = '{1'b0, 4'hF, 4'h4, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'h4};
    tbl[8]  = '{1'b0, 4'hF, 4'h4, 4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'h4};
    tbl[9]  = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[10] = '{1'b1, 4'hB, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[11] = '{1'b0, 4'hB, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1};
    tbl[12] = '{1'b0, 4'hB, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[13] = '{1'b0, 4'hB, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2};
    tbl[14] = '{1'b0, 4'hB, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[15] = '{1'b0, 4'hB, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'h8};
    tbl[16] = '{1'b0, 4'hB, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[17] = '{1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1};
    tbl[18] = '{1'b0, 4'hB, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};

    // Reset, then idle sources leave every output low.
    do_reset();
    repeat (3) cycle(4'hF, 1'b1);

    for (int r = 0; r < 19; r++) begin
      logic [N*DW-1:0] flat;
      logic [DW-1:0]   exp_d;
      if (tbl[r].rst) do_reset();
      @(negedge aclk);
      for (int i = 0; i < N; i++) flat[i*DW +: DW] = {8'(i + 1), 8'(r), 16'h5A00};
      src_enable    = tbl[r].en;
      s_axis_tvalid = tbl[r].valid;
      s_axis_tlast  = tbl[r].last;
      s_axis_tdata  = flat;
      m_axis_tready = tbl[r].mr;
      #1;
      exp_d = tbl[r].e_busy ? {8'(tbl[r].e_tid + 1), 8'(r), 16'h5A00} : '0;
      chk("tbl_busy", busy, tbl[r].e_busy);
      chk("tbl_m_tvalid", m_axis_tvalid, tbl[r].e_mvalid);
      chk("tbl_m_tlast", m_axis_tlast, tbl[r].e_tlast);
      chk("tbl_m_tid", m_axis_tid, tbl[r].e_tid);
      chk("tbl_s_tready", s_axis_tready, tbl[r].e_tready);
      chk("tbl_m_tdata", m_axis_tdata, exp_d);
    end

    // 40-beat src1 packet against a 16-beat src3 packet with MAX_BEATS = 16.
    do_reset();
    remaining[1] = 40; plen[1] = 40;
    remaining[3] = 16; plen[3] = 16;
    run_until_done(300, 1'b0);
    chk("mb_count", obs_q.size(), 56);
    for (int k = 0; k < obs_q.size() && k < 56; k++) begin
      chk("mb_tid", obs_q[k].tid, (k < 16) ? 1 : ((k < 32) ? 3 : 1));
      chk("mb_last", obs_q[k].last, (k == 31 || k == 55) ? 1 : 0);
    end

    // src2 streaming while m_axis_tready toggles; 20 beats crosses the MAX_BEATS split.
    do_reset();
    remaining[2] = 20; plen[2] = 20;
    run_until_done(300, 1'b1);
    chk("tg_count", obs_q.size(), 20);
    for (int k = 0; k < obs_q.size() && k < 20; k++) begin
      chk("tg_data", obs_q[k].data, {4'd2, 28'(k)});
      chk("tg_tid", obs_q[k].tid, 2);
      chk("tg_last", obs_q[k].last, (k == 19) ? 1 : 0);
    end

    // Asynchronous reset during beat 2 of a 5-beat grant.
    do_reset();
    remaining[0] = 5; plen[0] = 5;
    cycle(4'hF, 1'b1);
    cycle(4'hF, 1'b1);
    @(negedge aclk);
    drive_inputs(4'hF, 1'b1);
    #1;
    chk("mid_pre_m_tvalid", m_axis_tvalid, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_m_tvalid", m_axis_tvalid, 0);
    chk("mid_s_tready", s_axis_tready, 0);
    chk("mid_busy", busy, 0);
    do_reset();
    remaining[0] = 1; plen[0] = 1;
    remaining[1] = 1; plen[1] = 1;
    run_until_done(50, 1'b0);
    chk("mid_restart_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("mid_restart_first", obs_q[0].tid, 0);
      chk("mid_restart_second", obs_q[1].tid, 1);
    end

    // Randomized traffic, enables and backpressure against the reference model.
    do_reset();
    rnd_mode = 1;
    for (int i = 0; i < N; i++) begin
      remaining[i] = -1;
      plen[i] = $urandom_range(40, 1);
    end
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'hF,
            ($urandom_range(3) != 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
